// File: rtl/key_event_decoder_if.sv
// Key event bus: debounced key level toward the decoder, event pulses and busy back.
interface key_event_decoder_if;
    logic key_n;
    logic short_pulse;
    logic double_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic busy;

    modport master (
        output key_n,
        input  short_pulse, double_pulse, long_pulse, repeat_pulse, busy
    );

    modport slave (
        input  key_n,
        output short_pulse, double_pulse, long_pulse, repeat_pulse, busy
    );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced active-low key activity into short/double/long event pulses.
// Optional auto-repeat during a long hold is enabled by defining KEY_REPEAT_EN.
module key_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned DCLICK_CYCLES = 15_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic                clk,
    input  logic                reset,
    key_event_decoder_if.slave  key
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

    // Elaboration-time guard on the parameter range
    if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("key_event_decoder: all cycle parameters must be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG_HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             key_d;
    logic             short_q;
    logic             double_q;
    logic             long_q;
    logic             busy_q;
    logic             fall;
    logic             rise;

    assign fall = key_d & ~key.key_n;
    assign rise = ~key_d & key.key_n;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic repeat_q;
`endif

    // Edges always win over a coincident counter timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            counter  <= '0;
            key_d    <= 1'b1;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_q <= 1'b0;
`endif
        end else begin
            key_d    <= key.key_n;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= PRESS1;
                        counter <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (rise) begin
                        state   <= WAIT2;
                        counter <= '0;
                    end else if (counter == LONG_LAST) begin
                        long_q  <= 1'b1;
                        state   <= LONG_HOLD;
                        counter <= '0;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                WAIT2: begin
                    if (fall) begin
                        state   <= PRESS2;
                        counter <= '0;
                    end else if (counter == DCLICK_LAST) begin
                        short_q <= 1'b1;
                        state   <= IDLE;
                        counter <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                PRESS2: begin
                    if (rise) begin
                        double_q <= 1'b1;
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                LONG_HOLD: begin
                    if (rise) begin
                        state   <= IDLE;
                        counter <= '0;
                        busy_q  <= 1'b0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (counter == REPEAT_LAST) begin
                        repeat_q <= 1'b1;
                        counter  <= '0;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign key.short_pulse  = short_q;
    assign key.double_pulse = double_q;
    assign key.long_pulse   = long_q;
    assign key.busy         = busy_q;
`ifdef KEY_REPEAT_EN
    assign key.repeat_pulse = repeat_q;
`else
    assign key.repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: scoreboard of expected pulses keyed by cycle number.
module tb_key_event_decoder;

    localparam int unsigned LONG   = 20;
    localparam int unsigned DCLICK = 8;
    localparam int unsigned REP    = 5;

    localparam logic [3:0] K_SHORT  = 4'b1000;
    localparam logic [3:0] K_DOUBLE = 4'b0100;
    localparam logic [3:0] K_LONG   = 4'b0010;
    localparam logic [3:0] K_REP    = 4'b0001;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  kind;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    key_event_decoder_if bus ();

    key_event_decoder #(
        .LONG_CYCLES   (LONG),
        .DCLICK_CYCLES (DCLICK),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] pulses();
        return {bus.short_pulse, bus.double_pulse, bus.long_pulse, bus.repeat_pulse};
    endfunction

    // Every cycle: the pulse vector must equal the scoreboard entry due now, or zero
    always @(negedge clk) begin
        logic [3:0] expv;
        logic [3:0] obs;
        expv = 4'b0000;
        obs  = pulses();
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            expv = sb[0].kind;
            void'(sb.pop_front());
        end
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL pulses cyc=%0d observed=%b expected=%b", cyc, obs, expv);
        end
    end

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int unsigned at, input logic [3:0] kind);
        exp_t e;
        e.cyc  = at;
        e.kind = kind;
        sb.push_back(e);
    endtask

    // Wait for all expected pulses to be consumed, bounded
    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (sb.size() > 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout cyc=%0d observed=%0d pending expected=0", cyc, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int unsigned f;

        reset     = 1'b0;
        bus.key_n = 1'b1;
        step(3);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_pulses", |pulses(), 1'b0);
        reset = 1'b1;
        step(2);

        // Short press: 5 cycles low
        bus.key_n = 1'b0;
        step(1);
        check("short_busy_rise", bus.busy, 1'b1);
        step(4);
        bus.key_n = 1'b1;
        push(cyc + 1 + DCLICK, K_SHORT);
        drain(30);
        check("short_busy_fall", bus.busy, 1'b0);
        step(2);

        // Double click
        bus.key_n = 1'b0; step(4);
        bus.key_n = 1'b1; step(3);
        bus.key_n = 1'b0; step(4);
        bus.key_n = 1'b1;
        push(cyc + 1, K_DOUBLE);
        drain(30);
        check("double_busy_fall", bus.busy, 1'b0);
        step(2);

        // Long press, 40 cycles low; release coincides with would-be 4th repeat
        bus.key_n = 1'b0;
        f = cyc + 1;
        push(f + LONG, K_LONG);
`ifdef KEY_REPEAT_EN
        push(f + LONG + REP,     K_REP);
        push(f + LONG + 2 * REP, K_REP);
        push(f + LONG + 3 * REP, K_REP);
`endif
        step(40);
        check("long_busy_held", bus.busy, 1'b1);
        bus.key_n = 1'b1;
        step(2);
        check("long_busy_fall", bus.busy, 1'b0);
        drain(10);
        step(10);

        // Release on the cycle the counter hits LONG-1: no long pulse
        bus.key_n = 1'b0; step(20);
        bus.key_n = 1'b1;
        push(cyc + 1 + DCLICK, K_SHORT);
        drain(30);
        step(2);

        // Second press exactly at the double-click timeout
        bus.key_n = 1'b0; step(4);
        bus.key_n = 1'b1; step(8);
        bus.key_n = 1'b0; step(3);
        bus.key_n = 1'b1;
        push(cyc + 1, K_DOUBLE);
        drain(30);
        step(2);

        // Long-held second press yields only the double pulse
        bus.key_n = 1'b0; step(3);
        bus.key_n = 1'b1; step(2);
        bus.key_n = 1'b0; step(30);
        check("press2_busy_held", bus.busy, 1'b1);
        bus.key_n = 1'b1;
        push(cyc + 1, K_DOUBLE);
        drain(30);
        step(2);

        // Reset during WAIT2 aborts with no pulse
        bus.key_n = 1'b0; step(3);
        bus.key_n = 1'b1; step(4);
        check("wait2_busy", bus.busy, 1'b1);
        reset = 1'b0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_pulses", |pulses(), 1'b0);
        step(2);
        reset = 1'b1;
        step(15);
        check("abort_idle_busy", bus.busy, 1'b0);

        // Key held low through reset release counts as a new press
        reset = 1'b0;
        bus.key_n = 1'b0;
        step(2);
        check("held_reset_busy", bus.busy, 1'b0);
        reset = 1'b1;
        step(1);
        check("held_release_busy", bus.busy, 1'b1);
        step(3);
        bus.key_n = 1'b1;
        push(cyc + 1 + DCLICK, K_SHORT);
        drain(30);
        check("held_busy_fall", bus.busy, 1'b0);
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Classifies debounced key activity into discrete user events: single short press, double click, long press and, optionally, auto-repeat while held. It sits directly downstream of the key debouncer and takes its active-low debounced level. It emits single-cycle event pulses to the control FSMs, so those FSMs never need to time key presses themselves. Default parameters assume a 50 MHz clk.

## Interface
- LONG_CYCLES, 50_000_000 — hold time that qualifies a long press (1 s).
- DCLICK_CYCLES, 15_000_000 — maximum gap after a first release for a second press to count as a double click (300 ms).
- REPEAT_CYCLES, 10_000_000 — auto-repeat period while a long press is held (200 ms); used only with KEY_REPEAT_EN.
- Parameter rules: all parameters ≥ 2 and < 2^32. The internal counter is 32 bits and unsigned.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- key_n  input  1  debounced key level from the debouncer; 0 = pressed.
- short_pulse  output  1  one-cycle pulse: a single short press completed.
- double_pulse  output  1  one-cycle pulse: a double click completed.
- long_pulse  output  1  one-cycle pulse: the long-press threshold was reached while the key is held.
- repeat_pulse  output  1  one-cycle pulse per repeat period during a long hold.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- Reset values: state = IDLE; counter = 0; key_d = 1; all outputs = 0.
- key_d is a one-cycle delayed copy of key_n.
  - fall = key_d & ~key_n
  - rise = ~key_d & key_n
- States and transitions:
  - **IDLE:** on fall → PRESS1, counter cleared.
  - **PRESS1:** counter increments each cycle.
    - rise → WAIT2, counter cleared.
    - Otherwise, when counter == LONG_CYCLES-1 → long_pulse, LONG_HOLD, counter cleared.
  - **WAIT2:** counter increments each cycle.
    - fall → PRESS2.
    - Otherwise, when counter == DCLICK_CYCLES-1 → short_pulse, IDLE.
  - **PRESS2:** on rise → double_pulse, IDLE. There is no long-press detection in this state; a held second press yields only double_pulse at release.
  - **LONG_HOLD:** on rise → IDLE with no pulse. Repeat behaviour is described under Configuration.
- Simultaneous events: an edge always takes priority over a counter timeout in the same cycle.
  - rise at the long threshold → WAIT2; no long_pulse.
  - fall at the double-click timeout → PRESS2; no short_pulse.
- At most one output pulse is asserted in any cycle. All outputs are registered.
- A key already low when reset deasserts is seen as a fall, because key_d resets to 1. It is treated as a new press.
- Reset asserted mid-sequence aborts immediately to the reset values. No pulse is emitted for the aborted sequence.

## Timing
- State updates on the first clk edge at which the new key_n level is sampled. Edge-to-state latency is 1 cycle.
- long_pulse is high for exactly one cycle. It occurs LONG_CYCLES cycles after the edge that entered PRESS1.
- short_pulse is high for one cycle. It occurs DCLICK_CYCLES cycles after the edge that entered WAIT2. A short press is therefore reported only after the double-click window has expired.
- double_pulse is high for one cycle. It is asserted in the cycle following the edge that first samples key_n = 1 in PRESS2.
- busy rises 1 cycle after the fall that leaves IDLE. It falls in the same cycle as the terminating pulse, or 1 cycle after the release edge from LONG_HOLD.

## Configuration
- Macro: KEY_REPEAT_EN.
- **Defined:**
  - In LONG_HOLD the counter restarts at 0 on entry.
  - Each time it reaches REPEAT_CYCLES-1 it emits repeat_pulse and wraps to 0.
  - rise ends the hold and takes priority over a coincident repeat.
  - The first repeat_pulse occurs REPEAT_CYCLES cycles after long_pulse.
- **Undefined:**
  - repeat_pulse is tied to 0.
  - The counter is idle in LONG_HOLD.
  - REPEAT_CYCLES is unused.

## Test plan
All scenarios use LONG_CYCLES = 20, DCLICK_CYCLES = 8, REPEAT_CYCLES = 5.
- **Short press:** key_n low for 5 cycles, then high → one short_pulse 8 cycles after release; no other pulses; busy low afterwards.
- **Double click:** low 4 cycles, high 3 cycles, low 4 cycles, high → one double_pulse 1 cycle after the second release; no short_pulse.
- **Long press:** key_n low for 40 cycles → long_pulse 20 cycles after entering PRESS1. With KEY_REPEAT_EN, repeat_pulse at +5, +10, +15 after long_pulse; without it, repeat_pulse stays 0. No pulse on release.
- **Boundary:** release exactly on the cycle the counter hits 19 → no long_pulse; short_pulse follows 8 cycles later. A second press exactly at WAIT2 counter == 7 → double_pulse, no short_pulse.
- **Reset:** assert reset during WAIT2 → outputs 0, busy 0 immediately; no short_pulse after deassert with key_n high. Key held low through reset release → treated as a new press.
